// File: rtl/seq_game_pkg.sv
// Shared types and helpers for the game-flow controller: state encoding,
// in_vec bit positions and pattern-table indexing.
package seq_game_pkg;

    typedef enum logic [2:0] {
        ST_INI  = 3'd0,
        ST_IDLE = 3'd1,
        ST_PLAY = 3'd2,
        ST_DONE = 3'd3,
        ST_QUIZ = 3'd4,
        ST_WIN  = 3'd5,
        ST_LOSE = 3'd6
    } state_t;

    localparam int IDX_SW0  = 0;
    localparam int IDX_SW1  = 1;
    localparam int IDX_SW2  = 2;
    localparam int IDX_SW3  = 3;
    localparam int IDX_BTNL = 4;
    localparam int IDX_BTNR = 5;
    localparam int IDX_BTNU = 6;
    localparam int IDX_BTND = 7;

    // Bit offset of game g, step s inside the flat pattern table.
    function automatic int pat_offset(input int game, input int step,
                                      input int steps, input int width);
        return (game * steps + step) * width;
    endfunction

endpackage

// File: rtl/seq_step_matcher.sv
// Classifies the current input vector against the expected step pattern:
// match, or a wrong input that is neither the held previous pattern nor idle.
module seq_step_matcher
    import seq_game_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic [IN_W-1:0] i_in_vec,
    input  logic [IN_W-1:0] i_exp,
    input  logic [IN_W-1:0] i_prev,
    output logic            o_match,
    output logic            o_fail
);

    always_comb begin
        o_match = (i_in_vec == i_exp);
        o_fail  = !o_match && (i_in_vec != i_prev) && (i_in_vec != '0);
    end

endmodule

// File: rtl/seq_game_engine.sv
// Game-flow controller: sequences pattern games, interleaves timed professor
// quizzes, and tracks lives and the wall-clock limit. All outputs are flops.
//
//   state | meaning
//   INI   | counters cleared, waiting for Start
//   IDLE  | between attempts, Go enters PLAY
//   PLAY  | matching in_vec against the current game's step patterns
//   DONE  | game finished, waiting for inputs to be released
//   QUIZ  | professor question, answer on switches + Go before deadline
//   WIN   | all games done, Ack returns to INI
//   LOSE  | out of lives or time, Ack returns to INI
module seq_game_engine
    import seq_game_pkg::*;
#(
    parameter int NUM_GAMES = 3,
    parameter int STEPS     = 3,
    parameter int IN_W      = 8,
    parameter int SW_W      = 4,
    parameter logic [NUM_GAMES*STEPS*IN_W-1:0] PATTERNS = 72'h0E0602_703010_070301,
    parameter int NUM_QUIZ  = 3,
    parameter logic [NUM_QUIZ*SW_W-1:0] QUIZ_ANS = 12'hC5A,
    parameter int LIVES     = 3,
    parameter int MAX_TIME  = 120,
    parameter int QUIZ_TIME = 3,
    localparam int GW = (NUM_GAMES > 1) ? $clog2(NUM_GAMES) : 1,
    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1,
    localparam int QW = (NUM_QUIZ > 1) ? $clog2(NUM_QUIZ) : 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_ack,
    input  logic            i_go,
    input  logic            i_professor_req,
    input  logic [IN_W-1:0] i_in_vec,
    input  logic [7:0]      i_minutes,
    output logic [2:0]      o_state,
    output logic            o_screen,
    output logic [GW-1:0]   o_game_idx,
    output logic [SW-1:0]   o_step_idx,
    output logic [2:0]      o_lives,
    output logic [QW-1:0]   o_quiz_cnt,
    output logic            o_step_ok,
    output logic            o_strike
);

    localparam logic [GW-1:0] LAST_GAME  = GW'(NUM_GAMES - 1);
    localparam logic [SW-1:0] LAST_STEP  = SW'(STEPS - 1);
    localparam logic [QW-1:0] LAST_QUIZ  = QW'(NUM_QUIZ - 1);
    localparam logic [7:0]    MAX_T      = 8'(MAX_TIME);
    localparam logic [7:0]    QUIZ_T     = 8'(QUIZ_TIME);
    localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

    state_t          r_state;
    logic [GW-1:0]   r_game_idx;
    logic [SW-1:0]   r_step_idx;
    logic [2:0]      r_lives;
    logic [QW-1:0]   r_quiz_cnt;
    logic [7:0]      r_deadline;
    logic            r_screen;
    logic            r_step_ok;
    logic            r_strike;

    state_t          w_state_nxt;
    logic [GW-1:0]   w_game_nxt;
    logic [SW-1:0]   w_step_nxt;
    logic [2:0]      w_lives_nxt;
    logic [QW-1:0]   w_quiz_nxt;
    logic [QW-1:0]   w_quiz_inc;
    logic [7:0]      w_deadline_nxt;
    logic            w_step_ok_nxt;
    logic            w_strike_nxt;

    logic [SW-1:0]   w_prev_step;
    logic [IN_W-1:0] w_exp;
    logic [IN_W-1:0] w_prev;
    logic [SW_W-1:0] w_ans;
    logic            w_match;
    logic            w_fail;

    // prev is the pattern just accepted, so holding it does not count as wrong.
    always_comb begin
        w_prev_step = (r_step_idx == '0) ? '0 : r_step_idx - SW'(1);
        w_exp  = PATTERNS[pat_offset(int'(r_game_idx), int'(r_step_idx), STEPS, IN_W) +: IN_W];
        w_prev = (r_step_idx == '0) ? '0 :
                 PATTERNS[pat_offset(int'(r_game_idx), int'(w_prev_step), STEPS, IN_W) +: IN_W];
        w_ans  = QUIZ_ANS[int'(r_quiz_cnt) * SW_W +: SW_W];
    end

    seq_step_matcher #(
        .IN_W (IN_W)
    ) u_matcher (
        .i_in_vec (i_in_vec),
        .i_exp    (w_exp),
        .i_prev   (w_prev),
        .o_match  (w_match),
        .o_fail   (w_fail)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_game_nxt     = r_game_idx;
        w_step_nxt     = r_step_idx;
        w_lives_nxt    = r_lives;
        w_quiz_nxt     = r_quiz_cnt;
        w_deadline_nxt = r_deadline;
        w_step_ok_nxt  = 1'b0;
        w_strike_nxt   = 1'b0;
        w_quiz_inc     = (r_quiz_cnt == LAST_QUIZ) ? r_quiz_cnt : r_quiz_cnt + QW'(1);

        case (r_state)
            ST_INI: begin
                w_game_nxt = '0;
                w_step_nxt = '0;
                w_quiz_nxt = '0;
                if (i_start) begin
                    w_state_nxt = ST_IDLE;
                    w_lives_nxt = LIVES_INIT;
                end
            end
            ST_IDLE, ST_PLAY: begin
                if (i_minutes >= MAX_T) begin
                    w_state_nxt = ST_LOSE;
                end else if (i_professor_req) begin
                    w_state_nxt    = ST_QUIZ;
                    w_deadline_nxt = i_minutes + QUIZ_T;
                    w_step_nxt     = '0;
                end else if (r_state == ST_IDLE) begin
                    if (i_go) w_state_nxt = ST_PLAY;
                end else if (i_go) begin
                    w_state_nxt = ST_IDLE;
                    w_step_nxt  = '0;
                end else if (w_match) begin
                    w_step_ok_nxt = 1'b1;
                    if (r_step_idx == LAST_STEP) w_state_nxt = ST_DONE;
                    else                         w_step_nxt  = r_step_idx + SW'(1);
                end else if (w_fail) begin
                    w_state_nxt = ST_IDLE;
                    w_step_nxt  = '0;
                end
            end
            ST_DONE: begin
                if (i_in_vec == '0) begin
                    if (i_minutes >= MAX_T) begin
                        w_state_nxt = ST_LOSE;
                    end else if (r_game_idx == LAST_GAME) begin
                        w_state_nxt = ST_WIN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_game_nxt  = r_game_idx + GW'(1);
                        w_step_nxt  = '0;
                    end
                end
            end
            ST_QUIZ: begin
                // A correct Go on the deadline minute still counts as correct.
                if (i_go && (i_in_vec[SW_W-1:0] == w_ans)) begin
                    w_state_nxt = ST_IDLE;
                    w_quiz_nxt  = w_quiz_inc;
                end else if (i_go || (i_minutes == r_deadline)) begin
                    w_strike_nxt = 1'b1;
                    w_lives_nxt  = (r_lives == '0) ? '0 : r_lives - 3'd1;
                    w_state_nxt  = (r_lives <= 3'd1) ? ST_LOSE : ST_IDLE;
                    w_quiz_nxt   = w_quiz_inc;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (i_ack) begin
                    w_state_nxt = ST_INI;
                    w_game_nxt  = '0;
                    w_step_nxt  = '0;
                    w_quiz_nxt  = '0;
                end
            end
            default: w_state_nxt = ST_INI;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_INI;
            r_game_idx <= '0;
            r_step_idx <= '0;
            r_lives    <= '0;
            r_quiz_cnt <= '0;
            r_deadline <= '0;
            r_screen   <= 1'b0;
            r_step_ok  <= 1'b0;
            r_strike   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_game_idx <= w_game_nxt;
            r_step_idx <= w_step_nxt;
            r_lives    <= w_lives_nxt;
            r_quiz_cnt <= w_quiz_nxt;
            r_deadline <= w_deadline_nxt;
            r_screen   <= (w_state_nxt == ST_PLAY) || (w_state_nxt == ST_DONE);
            r_step_ok  <= w_step_ok_nxt;
            r_strike   <= w_strike_nxt;
        end
    end

    assign o_state    = r_state;
    assign o_screen   = r_screen;
    assign o_game_idx = r_game_idx;
    assign o_step_idx = r_step_idx;
    assign o_lives    = r_lives;
    assign o_quiz_cnt = r_quiz_cnt;
    assign o_step_ok  = r_step_ok;
    assign o_strike   = r_strike;

endmodule

// File: tb/tb_seq_game_engine.sv
// Directed bench for seq_game_engine: game flow, wrong inputs, quizzes,
// time limit, win and mid-game reset, with hand-computed expectations.
module tb_seq_game_engine;
    import seq_game_pkg::*;

    localparam logic [71:0] PATS = 72'h0E0602_703010_070301;
    localparam logic [11:0] ANS  = 12'hC5A;
    localparam logic [7:0]  PAT [0:2][0:2] = '{'{8'h01, 8'h03, 8'h07},
                                              '{8'h10, 8'h30, 8'h70},
                                              '{8'h02, 8'h06, 8'h0E}};

    logic       clk = 1'b0;
    logic       reset, start, ack, go, prof;
    logic [7:0] in_vec, minutes;
    logic [2:0] state;
    logic       screen;
    logic [1:0] game_idx, step_idx, quiz_cnt;
    logic [2:0] lives;
    logic       step_ok, strike;
    int         total = 0;
    int         bad = 0;
    int         n_ok;

    always #5 clk = ~clk;

    seq_game_engine #(
        .NUM_GAMES(3), .STEPS(3), .IN_W(8), .SW_W(4), .PATTERNS(PATS),
        .NUM_QUIZ(3), .QUIZ_ANS(ANS), .LIVES(3), .MAX_TIME(120), .QUIZ_TIME(3)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_ack(ack), .i_go(go),
        .i_professor_req(prof), .i_in_vec(in_vec), .i_minutes(minutes),
        .o_state(state), .o_screen(screen), .o_game_idx(game_idx),
        .o_step_idx(step_idx), .o_lives(lives), .o_quiz_cnt(quiz_cnt),
        .o_step_ok(step_ok), .o_strike(strike)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_steps(input int g, output int ok_cnt);
        ok_cnt = 0;
        in_vec = 8'h00; go = 1'b1; tick(); go = 1'b0;
        for (int s = 0; s < 3; s++) begin
            in_vec = PAT[g][s];
            tick();
            if (step_ok === 1'b1) ok_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        total++; if ({state, screen, game_idx, step_idx, lives, quiz_cnt, step_ok, strike} !== 16'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", {state, screen, game_idx, step_idx, lives, quiz_cnt, step_ok, strike}); end
    endtask

    task automatic test_game0();
        start = 1'b1; tick(); start = 1'b0;
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL start_state got=%0d exp=%0d", state, ST_IDLE); end
        total++; if (lives !== 3'd3) begin bad++; $display("FAIL start_lives got=%0d exp=3", lives); end
        go = 1'b1; tick(); go = 1'b0;
        total++; if (state !== ST_PLAY || screen !== 1'b1) begin bad++; $display("FAIL go_play state=%0d screen=%0d exp=%0d/1", state, screen, ST_PLAY); end
        in_vec = 8'h01; tick();
        total++; if (step_ok !== 1'b1 || step_idx !== 2'd1) begin bad++; $display("FAIL g0_step0 ok=%0d idx=%0d exp=1/1", step_ok, step_idx); end
        tick();
        total++; if (step_ok !== 1'b0 || step_idx !== 2'd1 || state !== ST_PLAY) begin bad++; $display("FAIL g0_hold ok=%0d idx=%0d state=%0d exp=0/1/%0d", step_ok, step_idx, state, ST_PLAY); end
        in_vec = 8'h03; tick();
        total++; if (step_ok !== 1'b1 || step_idx !== 2'd2) begin bad++; $display("FAIL g0_step1 ok=%0d idx=%0d exp=1/2", step_ok, step_idx); end
        in_vec = 8'h07; tick();
        total++; if (step_ok !== 1'b1 || state !== ST_DONE || screen !== 1'b1) begin bad++; $display("FAIL g0_done ok=%0d state=%0d screen=%0d exp=1/%0d/1", step_ok, state, screen, ST_DONE); end
        tick();
        total++; if (state !== ST_DONE || step_ok !== 1'b0) begin bad++; $display("FAIL g0_wait state=%0d ok=%0d exp=%0d/0", state, step_ok, ST_DONE); end
        in_vec = 8'h00; tick();
        total++; if (state !== ST_IDLE || game_idx !== 2'd1 || step_idx !== 2'd0 || screen !== 1'b0) begin bad++; $display("FAIL g0_next state=%0d game=%0d step=%0d screen=%0d exp=%0d/1/0/0", state, game_idx, step_idx, screen, ST_IDLE); end
    endtask

    task automatic test_wrong_and_abort();
        go = 1'b1; tick(); go = 1'b0;
        in_vec = 8'h10; tick();
        total++; if (step_idx !== 2'd1) begin bad++; $display("FAIL g1_step0 idx=%0d exp=1", step_idx); end
        in_vec = 8'h05; tick();
        total++; if (state !== ST_IDLE || step_idx !== 2'd0 || lives !== 3'd3 || strike !== 1'b0) begin bad++; $display("FAIL wrong_input state=%0d step=%0d lives=%0d strike=%0d exp=%0d/0/3/0", state, step_idx, lives, strike, ST_IDLE); end
        in_vec = 8'h00; go = 1'b1; tick(); go = 1'b0;
        in_vec = 8'h10; tick();
        in_vec = 8'h30; go = 1'b1; tick(); go = 1'b0;
        total++; if (state !== ST_IDLE || step_idx !== 2'd0 || step_ok !== 1'b0) begin bad++; $display("FAIL go_abort state=%0d step=%0d ok=%0d exp=%0d/0/0", state, step_idx, step_ok, ST_IDLE); end
        in_vec = 8'h00;
    endtask

    task automatic test_quiz_timeout();
        minutes = 8'd10; prof = 1'b1; tick(); prof = 1'b0;
        total++; if (state !== ST_QUIZ || screen !== 1'b0) begin bad++; $display("FAIL quiz_enter state=%0d screen=%0d exp=%0d/0", state, screen, ST_QUIZ); end
        minutes = 8'd11; tick();
        minutes = 8'd12; tick();
        total++; if (state !== ST_QUIZ || strike !== 1'b0) begin bad++; $display("FAIL quiz_wait state=%0d strike=%0d exp=%0d/0", state, strike, ST_QUIZ); end
        minutes = 8'd13; tick();
        total++; if (strike !== 1'b1 || lives !== 3'd2 || state !== ST_IDLE || quiz_cnt !== 2'd1) begin bad++; $display("FAIL quiz_timeout strike=%0d lives=%0d state=%0d quiz=%0d exp=1/2/%0d/1", strike, lives, state, quiz_cnt, ST_IDLE); end
        tick();
        total++; if (strike !== 1'b0) begin bad++; $display("FAIL strike_pulse got=%0d exp=0", strike); end
    endtask

    task automatic test_quiz_wrong_lose();
        minutes = 8'd20; prof = 1'b1; tick(); prof = 1'b0;
        in_vec = 8'h03; go = 1'b1; tick(); go = 1'b0;
        total++; if (strike !== 1'b1 || lives !== 3'd1 || state !== ST_IDLE || quiz_cnt !== 2'd2) begin bad++; $display("FAIL quiz_wrong strike=%0d lives=%0d state=%0d quiz=%0d exp=1/1/%0d/2", strike, lives, state, quiz_cnt, ST_IDLE); end
        in_vec = 8'h00; minutes = 8'd21; prof = 1'b1; tick(); prof = 1'b0;
        in_vec = 8'h03; go = 1'b1; tick(); go = 1'b0;
        total++; if (strike !== 1'b1 || lives !== 3'd0 || state !== ST_LOSE || quiz_cnt !== 2'd2) begin bad++; $display("FAIL quiz_lose strike=%0d lives=%0d state=%0d quiz=%0d exp=1/0/%0d/2", strike, lives, state, quiz_cnt, ST_LOSE); end
        in_vec = 8'h00; ack = 1'b1; tick(); ack = 1'b0;
        total++; if (state !== ST_INI || quiz_cnt !== 2'd0 || game_idx !== 2'd0) begin bad++; $display("FAIL ack_ini state=%0d quiz=%0d game=%0d exp=%0d/0/0", state, quiz_cnt, game_idx, ST_INI); end
    endtask

    task automatic test_quiz_deadline_correct();
        minutes = 8'd0; start = 1'b1; tick(); start = 1'b0;
        go = 1'b1; tick(); go = 1'b0;
        in_vec = 8'h01; tick();
        minutes = 8'd118; prof = 1'b1; tick(); prof = 1'b0;
        total++; if (state !== ST_QUIZ || step_idx !== 2'd0) begin bad++; $display("FAIL quiz_from_play state=%0d step=%0d exp=%0d/0", state, step_idx, ST_QUIZ); end
        minutes = 8'd120; tick();
        total++; if (state !== ST_QUIZ) begin bad++; $display("FAIL quiz_time_immune state=%0d exp=%0d", state, ST_QUIZ); end
        minutes = 8'd121; in_vec = 8'h0A; go = 1'b1; tick(); go = 1'b0;
        total++; if (state !== ST_IDLE || strike !== 1'b0 || lives !== 3'd3 || quiz_cnt !== 2'd1) begin bad++; $display("FAIL quiz_correct_deadline state=%0d strike=%0d lives=%0d quiz=%0d exp=%0d/0/3/1", state, strike, lives, quiz_cnt, ST_IDLE); end
        in_vec = 8'h00; tick();
        total++; if (state !== ST_LOSE) begin bad++; $display("FAIL idle_timeout state=%0d exp=%0d", state, ST_LOSE); end
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_play_timeout();
        minutes = 8'd0; start = 1'b1; tick(); start = 1'b0;
        go = 1'b1; tick(); go = 1'b0;
        minutes = 8'd120; tick();
        total++; if (state !== ST_LOSE || screen !== 1'b0) begin bad++; $display("FAIL play_timeout state=%0d screen=%0d exp=%0d/0", state, screen, ST_LOSE); end
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_done_timeout();
        minutes = 8'd0; start = 1'b1; tick(); start = 1'b0;
        drive_steps(0, n_ok);
        total++; if (state !== ST_DONE || n_ok != 3) begin bad++; $display("FAIL done_reach state=%0d oks=%0d exp=%0d/3", state, n_ok, ST_DONE); end
        minutes = 8'd120; prof = 1'b1; tick(); prof = 1'b0;
        total++; if (state !== ST_DONE) begin bad++; $display("FAIL done_immune state=%0d exp=%0d", state, ST_DONE); end
        in_vec = 8'h00; tick();
        total++; if (state !== ST_LOSE) begin bad++; $display("FAIL done_timeout state=%0d exp=%0d", state, ST_LOSE); end
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_win();
        minutes = 8'd0; start = 1'b1; tick(); start = 1'b0;
        for (int g = 0; g < 3; g++) begin
            drive_steps(g, n_ok);
            total++; if (state !== ST_DONE || n_ok != 3 || game_idx !== 2'(g)) begin bad++; $display("FAIL win_game%0d state=%0d oks=%0d game=%0d exp=%0d/3/%0d", g, state, n_ok, game_idx, ST_DONE, g); end
            in_vec = 8'h00; tick();
        end
        total++; if (state !== ST_WIN || game_idx !== 2'd2 || screen !== 1'b0) begin bad++; $display("FAIL win_state state=%0d game=%0d screen=%0d exp=%0d/2/0", state, game_idx, screen, ST_WIN); end
        ack = 1'b1; tick(); ack = 1'b0;
        total++; if (state !== ST_INI || game_idx !== 2'd0) begin bad++; $display("FAIL win_ack state=%0d game=%0d exp=%0d/0", state, game_idx, ST_INI); end
    endtask

    task automatic test_reset_mid_game();
        start = 1'b1; tick(); start = 1'b0;
        go = 1'b1; tick(); go = 1'b0;
        in_vec = 8'h01; tick();
        total++; if (state !== ST_PLAY || step_idx !== 2'd1) begin bad++; $display("FAIL mid_setup state=%0d step=%0d exp=%0d/1", state, step_idx, ST_PLAY); end
        reset = 1'b1; tick(); reset = 1'b0;
        total++; if ({state, screen, game_idx, step_idx, lives, quiz_cnt, step_ok, strike} !== 16'h0) begin bad++; $display("FAIL mid_reset got=%h exp=0", {state, screen, game_idx, step_idx, lives, quiz_cnt, step_ok, strike}); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ack = 1'b0; go = 1'b0; prof = 1'b0;
        in_vec = 8'h00; minutes = 8'd0;
        @(negedge clk);
        test_reset();
        test_game0();
        test_wrong_and_abort();
        test_quiz_timeout();
        test_quiz_wrong_lose();
        test_quiz_deadline_correct();
        test_play_timeout();
        test_done_timeout();
        test_win();
        test_reset_mid_game();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_game_engine.md
# seq_game_engine

Parametrised game-flow controller for the first-person-second-row game: it sequences NUM_GAMES input-pattern games of STEPS steps each and interleaves timed professor quizzes. It tracks lives and the wall-clock game limit. It sits between the debounced board inputs / minutes counter and the VGA/seven-segment display logic, which consume its registered status outputs. Game patterns and quiz answers are parameters, so new levels need no RTL change.

## Interface
- NUM_GAMES, 3: number of games; WIN after the last one.
- STEPS, 3: steps per game.
- IN_W, 8: width of in_vec, {BtnD,BtnU,BtnR,BtnL,Sw3,Sw2,Sw1,Sw0}.
- SW_W, 4: low in_vec bits used as the quiz answer.
- PATTERNS, NUM_GAMES*STEPS*IN_W bits: expected in_vec per step; game g, step s at offset (g*STEPS+s)*IN_W.
- NUM_QUIZ, 3: quiz table depth.
- QUIZ_ANS, NUM_QUIZ*SW_W bits: correct switch answer per quiz.
- LIVES, 3: lives loaded at Start (1..7).
- MAX_TIME, 120: minute limit. QUIZ_TIME, 3: minutes allowed per quiz.
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- Start, Ack, Go  in  1 each  single-cycle debounced pulses (Go = BtnC).
- professor_req  in  1  single-cycle pulse from the professor generator.
- in_vec  in  IN_W  debounced switch/button levels.
- minutes  in  8  elapsed minutes, monotonic.
- state  out  3  encoded state (package enum).
- screen  out  1  high in PLAY and DONE.
- game_idx  out  clog2(NUM_GAMES)  current game. step_idx  out  clog2(STEPS)  current step.
- lives  out  3. quiz_cnt  out  clog2(NUM_QUIZ)  current quiz index.
- step_ok, strike  out  1 each  one-cycle pulses: step accepted / life lost.

## Operation
- States: INI, IDLE, PLAY, DONE, QUIZ, WIN, LOSE.
- INI: clear game_idx, step_idx, quiz_cnt. Start → IDLE with lives=LIVES.
- Global priority in IDLE and PLAY, first match wins:
  1. minutes ≥ MAX_TIME → LOSE.
  2. professor_req → QUIZ, deadline = minutes+QUIZ_TIME (8-bit, mod 256), step_idx=0.
  3. state-local rules below.
- professor_req is ignored in INI, DONE, QUIZ, WIN and LOSE.
- IDLE: Go → PLAY.
- PLAY, checked against exp = PATTERNS[game_idx][step_idx] and prev = the previous step's pattern (0 at step 0):
  - Go → IDLE (abort), step_idx=0.
  - in_vec==exp → step_ok. Last step → DONE; otherwise step_idx+1.
  - in_vec≠exp, in_vec≠prev and in_vec≠0 → IDLE, step_idx=0, no strike.
  - Otherwise hold.
- DONE: immune to professor_req. Wait for in_vec==0, then:
  - minutes ≥ MAX_TIME → LOSE;
  - else last game → WIN;
  - else game_idx+1, step_idx=0 → IDLE.
- QUIZ: immune to MAX_TIME. ans = QUIZ_ANS[quiz_cnt].
  - Go with in_vec[SW_W-1:0]==ans → IDLE.
  - Go with a wrong answer, or minutes==deadline with no Go → strike, lives−1; → LOSE if lives was 1, else → IDLE.
  - Either exit sets quiz_cnt+1, saturating at NUM_QUIZ−1.
  - Correct Go in the same cycle as the deadline counts as correct.
- WIN, LOSE: Ack → INI.

## Timing
- All outputs registered and driven from flops; no combinational in→out path.
- Reset values: state=INI, game_idx=0, step_idx=0, lives=0, quiz_cnt=0, screen=0, step_ok=0, strike=0.
- Every transition and counter update appears the cycle after the sampled input edge.
- step_ok/strike assert exactly one cycle, aligned with the state update.
- deadline is compared by equality, so wrap past 255 works.
- Reset mid-game returns to INI the next cycle regardless of state.
- in_vec held at a matching pattern across cycles advances only once per step: after the advance, that pattern becomes prev.

## Structure
- Package seq_game_pkg holds:
  - state enum: INI=0, IDLE=1, PLAY=2, DONE=3, QUIZ=4, WIN=5, LOSE=6;
  - in_vec bit-index constants;
  - a pattern-slice helper function.
- Sub-module seq_step_matcher: combinational. Takes in_vec, exp and prev; returns match/fail. Unit-tested separately.
- Top: FSM, counters and deadline register. Target 200–300 lines.

## Test plan
- Default params; Start, Go, then in_vec 0x01, 0x03, 0x07, 0x00 for game 0 → three step_ok pulses, DONE, IDLE, game_idx=1.
- In PLAY step 1, drive in_vec=0x05 → IDLE, step_idx=0, lives unchanged (3), no strike.
- professor_req at minutes=10 → QUIZ, deadline 13. Hold until minutes=13 with no Go → strike, lives 3→2, IDLE, quiz_cnt=1.
- In QUIZ, Go with the wrong switch answer while lives=1 → strike, lives=0, LOSE. Ack → INI.
- minutes=120 while in PLAY → LOSE. minutes=120 while in QUIZ → stays in QUIZ. In DONE with in_vec released at minutes≥120 → LOSE.
- Complete all three games → WIN. Assert Reset mid-PLAY of a second run → next cycle all outputs at reset values.
